sn76489_psg: RTL and testbench
==============================

// Module: sn76489_psg
// PURPOSE
//  SN76489-compatible programmable sound generator: three square-wave tone channels plus one noise channel.
//  Each channel has its own attenuator; the channels are mixed into one signed sample.
//  The CPU writes it over an 8-bit write-only bus with a ready handshake.
//  It is the top-level audio block; its per-channel levels are exported for frequency-detector checking.
// PARAMETERS
//  CLOCK_DIV_16  1  1: divide enabled clocks by 16 internally to form the generator tick; 0: every clock_en_i is a tick
// PORTS
//  clock_i     in   1  system clock; all logic on rising edge
//  res_i       in   1  reset, asynchronous, active-high
//  clock_en_i  in   1  PSG clock enable (chip clock rate)
//  ce_n_i      in   1  chip enable, active-low
//  we_n_i      in   1  write enable, active-low
//  d_i         in   8  write data byte
//  ready_o     out  1  1 = idle / can accept a write; 0 = write in progress
//  tone1_o     out  1  raw square output, tone channel 1
//  tone2_o     out  1  raw square output, tone channel 2
//  tone3_o     out  1  raw square output, tone channel 3
//  noise_o     out  1  LFSR bit 0, noise channel
//  aout_o      out  8  signed mixed audio sample (two's complement)
// BEHAVIOUR
//  Reset (async, res_i=1):
//   - Tone f_q = 0; all attenuation a_q = 15 (silent); noise ctrl = 0; LFSR = 15'h4000.
//   - Latched register = 0; tone counters = 0; all raw outputs = 0.
//   - ready_o = 1; aout_o = 0. Reset asserted mid-write aborts the write.
//  Register map (reg[2:0]):
//   - 0/2/4: tone1/2/3 frequency, 10 bits. 1/3/5: tone1/2/3 attenuation, 4 bits.
//   - 6: noise ctrl {fb, nf[1:0]}. 7: noise attenuation.
//  Write protocol:
//   - A write is accepted in the cycle where ce_n_i=0, we_n_i=0 and ready_o=1.
//   - Latch byte, d_i[7]=1: reg <= d_i[6:4]; the register's low 4 bits <= d_i[3:0] (attenuation: whole value; noise ctrl: d_i[2:0]).
//   - Data byte, d_i[7]=0: if the latched reg is a tone frequency, f_q[9:4] <= d_i[5:0]; otherwise the register's low bits <= d_i[3:0].
//   - Any write to reg 6 reloads the LFSR with 15'h4000.
//   - ready_o goes 0 the cycle after acceptance and stays 0 for 32 clock_en_i pulses, then returns to 1.
//   - A further write needs ce_n_i or we_n_i to return high first (one write per strobe).
//   - Register contents are updated on the accept edge, so a read-back through hierarchy sees the new value the next cycle.
//  Timebase:
//   - Generator tick = every 16th clock_en_i pulse (CLOCK_DIV_16=1), else every clock_en_i pulse.
//  Tone channel (per tick):
//   - 10-bit down counter; when the counter is 0 or 1 it reloads f_q and toggles the output.
//   - So the period is 2*f_q ticks; f_q=0 or 1 forces the output constant 1.
//  Noise channel:
//   - Shift clock = a rising toggle of an internal divider: nf 00 = N/512, 01 = N/1024, 10 = N/2048 (in clock_en units); 11 = rising edge of tone3_o.
//   - On each shift: lfsr <= {fb ? lfsr[0]^lfsr[1] : lfsr[0], lfsr[14:1]}; noise_o = lfsr[0].
//  Attenuation / mix:
//   - Amplitude table (a=0..15): 31,25,20,16,12,10,8,6,5,4,3,2,2,1,1,0.
//   - Each channel contributes +amp when its raw output is 1 and -amp when 0; a=15 contributes 0.
//   - aout_o = registered signed sum of the 4 channels, range -124..+124, no saturation needed; updates 1 clock after the tick.
// TESTING
//  - Reset: apply res_i, then check all a_q=15, f_q=0, ready_o=1, aout_o=0.
//  - Register sweep: for r=0..7 write 0x80|(r<<4)|(r+1) -> reg r low bits = r+1; each write lowers ready_o for 32 clock_en pulses.
//  - Two-byte tone: write 0x8A then 0x12 -> tone1 f_q=0x12A.
//  - Tone1 period: f_q=5, a=0, CLOCK_DIV_16=1, clock_en_i=1 -> tone1_o period = 160 clocks; aout_o swings ±31.
//  - Noise: write 0xE4 (white, N/512) then 0xF0 -> LFSR restarts at 15'h4000; noise_o toggles pseudo-randomly; periodic mode (0xE0) gives a 15-step pattern.
//  - Handshake: hold ce_n_i=we_n_i=0 across the busy window -> only one write is taken; res_i mid-write -> ready_o=1 immediately.

Source files
------------

// File: rtl/sn76489_psg.sv
// SN76489-style PSG: three square tone channels, one LFSR noise channel,
// per-channel attenuation, mixed into a signed 8-bit sample.
module sn76489_psg #(
    parameter bit CLOCK_DIV_16 = 1'b1
) (
    input  logic       clock_i,
    input  logic       res_i,
    input  logic       clock_en_i,
    input  logic       ce_n_i,
    input  logic       we_n_i,
    input  logic [7:0] d_i,
    output logic       ready_o,
    output logic       tone1_o,
    output logic       tone2_o,
    output logic       tone3_o,
    output logic       noise_o,
    output logic [7:0] aout_o
);

    logic [9:0]  f_q [3];
    logic [3:0]  a_q [4];
    logic [9:0]  cnt_q [3];
    logic [2:0]  tone_q;
    logic [2:0]  nctl_q;
    logic [2:0]  reg_q;
    logic [14:0] lfsr_q;
    logic        armed_q;
    logic        ready_q;
    logic [4:0]  busy_q;
    logic [3:0]  pre_q;
    logic [10:0] ncnt_q;
    logic        t3_d_q;
    logic signed [7:0] aout_q;
    logic signed [7:0] mix;

    logic       accept;
    logic       tick;
    logic       shift;
    logic [2:0] wreg;
    logic       tone_w;
    logic       wf_hi;
    logic       wf_lo;
    logic       wa;
    logic       wn;

    assign accept = !ce_n_i && !we_n_i && ready_q && armed_q;
    assign wreg   = d_i[7] ? d_i[6:4] : reg_q;
    assign tone_w = !wreg[0] && (wreg != 3'd6);
    assign wf_hi  = tone_w && !d_i[7];
    assign wf_lo  = tone_w && d_i[7];
    assign wa     = wreg[0];
    assign wn     = (wreg == 3'd6);

    assign tick = clock_en_i && (!CLOCK_DIV_16 || pre_q == 4'hF);

    always_ff @(posedge clock_i or posedge res_i) begin
        if (res_i) begin
            for (int i = 0; i < 3; i++) f_q[i] <= '0;
            for (int i = 0; i < 4; i++) a_q[i] <= 4'hF;
            nctl_q <= '0;
            reg_q  <= '0;
        end else if (accept) begin
            if (d_i[7]) reg_q <= d_i[6:4];
            unique case (1'b1)
                wf_hi: f_q[wreg[2:1]][9:4] <= d_i[5:0];
                wf_lo: f_q[wreg[2:1]][3:0] <= d_i[3:0];
                wa:    a_q[wreg[2:1]] <= d_i[3:0];
                wn:    nctl_q <= d_i[2:0];
            endcase
        end
    end

    // armed_q enforces one write per ce/we strobe
    always_ff @(posedge clock_i or posedge res_i) begin
        if (res_i) begin
            armed_q <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= '0;
        end else begin
            if (ce_n_i || we_n_i) armed_q <= 1'b1;
            else if (accept) armed_q <= 1'b0;
            if (accept) begin
                ready_q <= 1'b0;
                busy_q  <= '0;
            end else if (!ready_q && clock_en_i) begin
                busy_q <= busy_q + 5'd1;
                if (busy_q == 5'd31) ready_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or posedge res_i) begin
        if (res_i) begin
            pre_q  <= '0;
            ncnt_q <= '0;
            t3_d_q <= 1'b0;
        end else begin
            t3_d_q <= tone_q[2];
            if (clock_en_i) begin
                pre_q  <= pre_q + 4'd1;
                ncnt_q <= ncnt_q + 11'd1;
            end
        end
    end

    // f_q of 0 or 1 parks the square output high
    always_ff @(posedge clock_i or posedge res_i) begin
        if (res_i) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            tone_q <= '0;
        end else if (tick) begin
            for (int i = 0; i < 3; i++) begin
                if (f_q[i] <= 10'd1) begin
                    cnt_q[i]  <= f_q[i];
                    tone_q[i] <= 1'b1;
                end else if (cnt_q[i] <= 10'd1) begin
                    cnt_q[i]  <= f_q[i];
                    tone_q[i] <= !tone_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] - 10'd1;
                end
            end
        end
    end

    always_comb begin
        shift = 1'b0;
        unique case (nctl_q[1:0])
            2'd0: shift = clock_en_i && (&ncnt_q[8:0]);
            2'd1: shift = clock_en_i && (&ncnt_q[9:0]);
            2'd2: shift = clock_en_i && (&ncnt_q);
            2'd3: shift = tone_q[2] && !t3_d_q;
        endcase
    end

    always_ff @(posedge clock_i or posedge res_i) begin
        if (res_i) begin
            lfsr_q <= 15'h4000;
        end else if (accept && wn) begin
            lfsr_q <= 15'h4000;
        end else if (shift) begin
            lfsr_q <= {nctl_q[2] ? lfsr_q[0] ^ lfsr_q[1] : lfsr_q[0],
                       lfsr_q[14:1]};
        end
    end

    function automatic logic [4:0] amp(input logic [3:0] a);
        logic [4:0] v;
        unique case (a)
            4'd0:  v = 5'd31;
            4'd1:  v = 5'd25;
            4'd2:  v = 5'd20;
            4'd3:  v = 5'd16;
            4'd4:  v = 5'd12;
            4'd5:  v = 5'd10;
            4'd6:  v = 5'd8;
            4'd7:  v = 5'd6;
            4'd8:  v = 5'd5;
            4'd9:  v = 5'd4;
            4'd10: v = 5'd3;
            4'd11: v = 5'd2;
            4'd12: v = 5'd2;
            4'd13: v = 5'd1;
            4'd14: v = 5'd1;
            4'd15: v = 5'd0;
        endcase
        return v;
    endfunction

    function automatic logic signed [7:0] lvl(input logic [3:0] a,
                                              input logic o);
        logic signed [7:0] v;
        v = signed'({3'b000, amp(a)});
        return o ? v : -v;
    endfunction

    always_comb begin
        mix = lvl(a_q[0], tone_q[0]) + lvl(a_q[1], tone_q[1])
            + lvl(a_q[2], tone_q[2]) + lvl(a_q[3], lfsr_q[0]);
    end

    always_ff @(posedge clock_i or posedge res_i) begin
        if (res_i) aout_q <= '0;
        else aout_q <= mix;
    end

    assign ready_o = ready_q;
    assign tone1_o = tone_q[0];
    assign tone2_o = tone_q[1];
    assign tone3_o = tone_q[2];
    assign noise_o = lfsr_q[0];
    assign aout_o  = aout_q;

endmodule

// File: tb/tb_sn76489_psg.sv
// Directed bench for sn76489_psg: register map, write handshake,
// tone period/mix and noise LFSR sequences.
module tb_sn76489_psg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b1;
    logic       ce_n = 1'b1;
    logic       we_n = 1'b1;
    logic [7:0] d = '0;
    logic       ready_o;
    logic       tone1_o;
    logic       tone2_o;
    logic       tone3_o;
    logic       noise_o;
    logic [7:0] aout_o;

    int errs = 0;
    int checks = 0;
    logic [14:0] lfsr_acc;

    typedef struct {
        logic [7:0] d;
        int         r;
        int         exp;
    } vec_t;

    vec_t v [14];

    sn76489_psg #(.CLOCK_DIV_16(1'b1)) dut (
        .clock_i(clk),
        .res_i(rst),
        .clock_en_i(cen),
        .ce_n_i(ce_n),
        .we_n_i(we_n),
        .d_i(d),
        .ready_o(ready_o),
        .tone1_o(tone1_o),
        .tone2_o(tone2_o),
        .tone3_o(tone3_o),
        .noise_o(noise_o),
        .aout_o(aout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int get_reg(input int r);
        case (r)
            0: return int'(dut.f_q[0]);
            1: return int'(dut.a_q[0]);
            2: return int'(dut.f_q[1]);
            3: return int'(dut.a_q[1]);
            4: return int'(dut.f_q[2]);
            5: return int'(dut.a_q[2]);
            6: return int'(dut.nctl_q);
            default: return int'(dut.a_q[3]);
        endcase
    endfunction

    function automatic int sval(input logic [7:0] x);
        return int'($signed(x));
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        ce_n = 1'b1;
        we_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] b, output int busy);
        ce_n = 1'b0;
        we_n = 1'b0;
        d = b;
        @(negedge clk);
        ce_n = 1'b1;
        we_n = 1'b1;
        lfsr_acc = dut.lfsr_q;
        busy = 0;
        while (!ready_o && busy < 100) begin
            busy++;
            @(negedge clk);
        end
    endtask

    task automatic wait_rise(output int n);
        logic last;
        bit hit;
        last = tone1_o;
        hit = 1'b0;
        n = 0;
        while (!hit && n < 1000) begin
            @(negedge clk);
            n++;
            hit = !last && tone1_o;
            last = tone1_o;
        end
    endtask

    task automatic run_noise(input logic [7:0] ctl, input int nsh);
        logic [14:0] m;
        logic [14:0] last;
        int gap;
        ce_n = 1'b0;
        we_n = 1'b0;
        d = ctl;
        @(negedge clk);
        ce_n = 1'b1;
        we_n = 1'b1;
        chk("lfsr_reload", int'(dut.lfsr_q), 'h4000);
        m = 15'h4000;
        last = m;
        for (int k = 0; k < nsh; k++) begin
            gap = 0;
            while (dut.lfsr_q == last && gap < 600) begin
                @(negedge clk);
                gap++;
            end
            m = {ctl[2] ? m[0] ^ m[1] : m[0], m[14:1]};
            chk("lfsr_step", int'(dut.lfsr_q), int'(m));
            chk("noise_o", int'(noise_o), int'(m[0]));
            if (k > 0) chk("shift_gap", gap, 512);
            last = dut.lfsr_q;
        end
        @(negedge clk);
        chk("noise_mix", sval(aout_o), m[0] ? 31 : -31);
    endtask

    initial begin
        int busy;
        int n;
        int low;

        v[0]  = '{8'h81, 0, 1};
        v[1]  = '{8'h92, 1, 2};
        v[2]  = '{8'hA3, 2, 3};
        v[3]  = '{8'hB4, 3, 4};
        v[4]  = '{8'hC5, 4, 5};
        v[5]  = '{8'hD6, 5, 6};
        v[6]  = '{8'hE7, 6, 7};
        v[7]  = '{8'hF8, 7, 8};
        v[8]  = '{8'h8A, 0, 'h00A};
        v[9]  = '{8'h12, 0, 'h12A};
        v[10] = '{8'hB3, 3, 3};
        v[11] = '{8'h07, 3, 7};
        v[12] = '{8'hE5, 6, 5};
        v[13] = '{8'h02, 6, 2};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) chk("rst_atten", get_reg(2 * i + 1), 15);
        for (int i = 0; i < 3; i++) chk("rst_freq", get_reg(2 * i), 0);
        chk("rst_ready", int'(ready_o), 1);
        chk("rst_aout", sval(aout_o), 0);
        chk("rst_lfsr", int'(dut.lfsr_q), 'h4000);
        chk("rst_tone1", int'(tone1_o), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            wr(v[i].d, busy);
            chk($sformatf("reg_%0d_wr%0d", v[i].r, i), get_reg(v[i].r), v[i].exp);
            chk("busy_len", busy, 32);
        end

        do_reset();
        ce_n = 1'b0;
        we_n = 1'b0;
        d = 8'h91;
        @(negedge clk);
        d = 8'h95;
        low = 0;
        for (int i = 0; i < 60; i++) begin
            if (!ready_o) low++;
            @(negedge clk);
        end
        chk("hold_one_write", get_reg(1), 1);
        chk("hold_busy_len", low, 32);
        chk("hold_ready", int'(ready_o), 1);
        ce_n = 1'b1;
        we_n = 1'b1;
        @(negedge clk);

        d = 8'h9A;
        ce_n = 1'b0;
        we_n = 1'b0;
        @(negedge clk);
        ce_n = 1'b1;
        we_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midwrite_busy", int'(ready_o), 0);
        #1 rst = 1'b1;
        #1;
        chk("midwrite_rst_ready", int'(ready_o), 1);
        chk("midwrite_rst_atten", get_reg(1), 15);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        wr(8'h85, busy);
        wr(8'h00, busy);
        wr(8'h90, busy);
        chk("tone_freq", get_reg(0), 5);
        wait_rise(n);
        chk("tone_first_rise", int'(n < 1000), 1);
        wait_rise(n);
        chk("tone_period", n, 160);
        repeat (5) @(negedge clk);
        chk("tone_hi_a0", sval(aout_o), 31);
        repeat (80) @(negedge clk);
        chk("tone_lo_a0", sval(aout_o), -31);
        wr(8'h92, busy);
        wait_rise(n);
        repeat (5) @(negedge clk);
        chk("tone_hi_a2", sval(aout_o), 20);
        repeat (80) @(negedge clk);
        chk("tone_lo_a2", sval(aout_o), -20);
        wr(8'h9F, busy);
        repeat (2) @(negedge clk);
        chk("tone_silent", sval(aout_o), 0);

        do_reset();
        wr(8'hF0, busy);
        run_noise(8'hE4, 20);
        run_noise(8'hE0, 15);
        chk("lfsr_period15", int'(dut.lfsr_q), 'h4000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
